// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbitration protocol: requester state, result codes, default widths.
// Used by the requester as well as the arbiter and target models.
package bus_pkg;

    localparam int BUS_ADDR_W    = 16;
    localparam int BUS_DATA_W    = 16;
    localparam int BUS_BURST_MAX = 8;
    localparam int BUS_TIMEOUT   = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_ADDRESS = 3'd2,
        ST_DATA    = 3'd3,
        ST_RELEASE = 3'd4
    } bus_state_e;

    typedef enum logic [2:0] {
        STS_OK        = 3'd0,
        STS_TO_GRANT  = 3'd1,
        STS_TO_TARGET = 3'd2,
        STS_PREEMPT   = 3'd3,
        STS_BUS_ERR   = 3'd4
    } bus_status_e;

    // True while the requester is asking for or holding the bus.
    function automatic logic bus_owned(input bus_state_e s);
        return (s == ST_REQUEST) || (s == ST_ADDRESS) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/bus_timeout.sv
// Saturating wait counter: expires after TimeoutCycles consecutive enabled cycles without a clear.
module bus_timeout #(
    parameter int TimeoutCycles = 64
) (
    input  logic clk,
    input  logic Reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    logic [CntW-1:0] r_count;

    assign o_expired = (r_count == CntW'(TimeoutCycles - 1));

    // Count enabled cycles, holding once expired so the value never wraps.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + CntW'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/bus_requester.sv
// Shared-bus initiator: requests the bus, runs address and data phases with the target,
// then releases the bus and reports a result code with a one-cycle done pulse.
module bus_requester
    import bus_pkg::*;
#(
    parameter int AddrWidth     = BUS_ADDR_W,
    parameter int DataWidth     = BUS_DATA_W,
    parameter int BurstMax      = BUS_BURST_MAX,
    parameter int TimeoutCycles = BUS_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AddrWidth-1:0]        cmd_addr,
    input  logic [$clog2(BurstMax)-1:0] cmd_len,
    input  logic [DataWidth-1:0]        wdata,
    input  logic                        wdata_valid,
    output logic                        wdata_ready,
    output logic [DataWidth-1:0]        rdata,
    output logic                        rdata_valid,
    output logic                        done,
    output logic [2:0]                  status,
    output logic                        BARQ,
    input  logic                        BAGD,
    output logic                        AddressValid,
    output logic [AddrWidth-1:0]        Address,
    output logic                        WriteEn,
    input  logic                        TargetReady,
    output logic                        DataStrobe,
    output logic [DataWidth-1:0]        BusDataOut,
    input  logic [DataWidth-1:0]        BusDataIn,
    input  logic                        Error
);

    localparam int LenW = $clog2(BurstMax);

    bus_state_e           r_state;
    bus_state_e           w_next;
    bus_status_e          w_code;
    bus_status_e          r_status;

    logic                 r_write;
    logic [AddrWidth-1:0] r_addr;
    logic [LenW-1:0]      r_len;
    logic [LenW-1:0]      r_beat;

    logic                 r_cmd_ready;
    logic                 r_barq;
    logic                 r_addr_valid;
    logic [AddrWidth-1:0] r_address;
    logic                 r_write_en;
    logic                 r_data_phase;
    logic                 r_done;
    logic                 r_rdata_valid;
    logic [DataWidth-1:0] r_rdata;
    logic                 r_bagd_q;

    logic                 w_take;
    logic                 w_preempt;
    logic                 w_strobe;
    logic                 w_hs;
    logic                 w_accept;
    logic                 w_expired;
    logic                 w_to_clr;
    logic                 w_to_en;

    // r_bagd_q is only ever set once the grant has been seen, so a drop here is a real preemption.
    assign w_take    = (r_state == ST_IDLE) & r_cmd_ready & cmd_valid;
    assign w_preempt = r_bagd_q & ~BAGD;
    assign w_strobe  = r_data_phase & (~r_write | wdata_valid);
    assign w_hs      = w_strobe & TargetReady;

    // Next state and result code; abort causes are ranked Error, preemption, timeout.
    always_comb begin
        w_next   = r_state;
        w_code   = STS_OK;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_next = ST_REQUEST;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (Error) begin
                    w_next = ST_RELEASE;
                    w_code = STS_BUS_ERR;
                end else if (w_preempt) begin
                    w_next = ST_RELEASE;
                    w_code = STS_PREEMPT;
                end else if (w_expired) begin
                    w_next = ST_RELEASE;
                    w_code = STS_TO_GRANT;
                end else if (BAGD) begin
                    w_next = ST_ADDRESS;
                end else begin
                    w_next = ST_REQUEST;
                end
            end
            ST_ADDRESS: begin
                if (Error) begin
                    w_next = ST_RELEASE;
                    w_code = STS_BUS_ERR;
                end else if (w_preempt) begin
                    w_next = ST_RELEASE;
                    w_code = STS_PREEMPT;
                end else if (w_expired) begin
                    w_next = ST_RELEASE;
                    w_code = STS_TO_TARGET;
                end else if (TargetReady) begin
                    w_next = ST_DATA;
                end else begin
                    w_next = ST_ADDRESS;
                end
            end
            ST_DATA: begin
                if (Error) begin
                    w_next = ST_RELEASE;
                    w_code = STS_BUS_ERR;
                end else if (w_preempt) begin
                    w_next = ST_RELEASE;
                    w_code = STS_PREEMPT;
                end else if (w_expired) begin
                    w_next = ST_RELEASE;
                    w_code = STS_TO_TARGET;
                end else if (w_hs) begin
                    w_accept = 1'b1;
                    if (r_beat == r_len) begin
                        w_next = ST_RELEASE;
                        w_code = STS_OK;
                    end else begin
                        w_next = ST_DATA;
                    end
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_RELEASE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_to_clr = (w_next != r_state) | w_accept;
    assign w_to_en  = bus_owned(r_state);

    bus_timeout #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .clk      (clk),
        .Reset    (Reset),
        .i_clr    (w_to_clr),
        .i_en     (w_to_en),
        .o_expired(w_expired)
    );

    // State register plus the captured command and beat count.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_write <= cmd_write;
                r_addr  <= cmd_addr;
                r_len   <= cmd_len;
                r_beat  <= '0;
            end else if (w_accept) begin
                r_beat  <= r_beat + LenW'(1);
            end else begin
                r_beat  <= r_beat;
            end
        end
    end

    // Outputs are decoded from the next state so each one is a flop aligned with the state.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_cmd_ready   <= 1'b0;
            r_barq        <= 1'b0;
            r_addr_valid  <= 1'b0;
            r_address     <= '0;
            r_write_en    <= 1'b0;
            r_data_phase  <= 1'b0;
            r_done        <= 1'b0;
            r_status      <= STS_OK;
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
            r_bagd_q      <= 1'b0;
        end else begin
            r_cmd_ready   <= (w_next == ST_IDLE);
            r_barq        <= bus_owned(w_next);
            r_addr_valid  <= (w_next == ST_ADDRESS);
            r_address     <= (w_next == ST_ADDRESS) ? r_addr : '0;
            r_write_en    <= ((w_next == ST_ADDRESS) || (w_next == ST_DATA)) ? r_write : 1'b0;
            r_data_phase  <= (w_next == ST_DATA);
            r_done        <= (w_next == ST_RELEASE);
            r_status      <= (w_next == ST_RELEASE) ? w_code : STS_OK;
            r_rdata_valid <= w_accept & ~r_write;
            r_rdata       <= (w_accept & ~r_write) ? BusDataIn : r_rdata;
            r_bagd_q      <= ((r_state != ST_IDLE) && bus_owned(w_next)) ? BAGD : 1'b0;
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign BARQ         = r_barq;
    assign AddressValid = r_addr_valid;
    assign Address      = r_address;
    assign WriteEn      = r_write_en;
    assign done         = r_done;
    assign status       = r_status;
    assign rdata_valid  = r_rdata_valid;
    assign rdata        = r_rdata;
    // Write strobe and beat acknowledge follow the local data handshake in the same cycle.
    assign DataStrobe   = w_strobe;
    assign wdata_ready  = w_accept & r_write;
    assign BusDataOut   = (r_data_phase & r_write) ? wdata : '0;

endmodule

// File: tb/tb_bus_requester.sv
// Randomized bench for bus_requester: a procedural per-transaction model predicts every output each cycle.
module tb_bus_requester;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        Reset, cmd_valid, cmd_write, wdata_valid, BAGD, TargetReady, Error;
    logic [15:0] cmd_addr, wdata, BusDataIn;
    logic [2:0]  cmd_len;
    logic        cmd_ready, wdata_ready, rdata_valid, done, BARQ, AddressValid, WriteEn, DataStrobe;
    logic [15:0] rdata, Address, BusDataOut;
    logic [2:0]  status;

    always #5 clk = ~clk;

    bus_requester dut (
        .clk(clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .status(status),
        .BARQ(BARQ), .BAGD(BAGD), .AddressValid(AddressValid), .Address(Address),
        .WriteEn(WriteEn), .TargetReady(TargetReady), .DataStrobe(DataStrobe),
        .BusDataOut(BusDataOut), .BusDataIn(BusDataIn), .Error(Error)
    );

    int n_vec = 0;
    int n_err = 0;

    // Expected outputs for the cycle about to be sampled.
    logic        e_cmd_ready, e_barq, e_av, e_we, e_dphase, e_done, e_rvalid, e_wready, e_wr;
    logic [15:0] e_addr, e_rdata, e_bdo;
    logic [2:0]  e_status;
    logic [15:0] wbeat [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rnd(input int p);
        return int'($urandom_range(999)) < p;
    endfunction

    // Sample on the falling edge, then move to just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        check_eq("cmd_ready", cmd_ready, e_cmd_ready);
        check_eq("BARQ", BARQ, e_barq);
        check_eq("AddressValid", AddressValid, e_av);
        check_eq("Address", Address, e_addr);
        check_eq("WriteEn", WriteEn, e_we);
        check_eq("done", done, e_done);
        if (e_done) check_eq("status", status, e_status);
        check_eq("rdata_valid", rdata_valid, e_rvalid);
        if (e_rvalid) check_eq("rdata", rdata, e_rdata);
        check_eq("DataStrobe", DataStrobe, e_dphase & (~e_wr | wdata_valid));
        check_eq("wdata_ready", wdata_ready, e_wready);
        check_eq("BusDataOut", BusDataOut, (e_dphase && e_wr) ? e_bdo : 16'h0000);
        @(posedge clk);
        #1;
        e_rvalid = 1'b0;
        e_wready = 1'b0;
    endtask

    task automatic noise();
        BAGD        = $urandom_range(1);
        Error       = rnd(50);
        TargetReady = $urandom_range(1);
        wdata_valid = $urandom_range(1);
        wdata       = 16'($urandom);
        BusDataIn   = 16'($urandom);
    endtask

    task automatic idle_cycle();
        cmd_valid = 1'b0;
        noise();
        cycle();
    endtask

    task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [2:0] len,
                           input int p_gnt, input int p_tr, input int p_err,
                           input int p_drop, input int p_wv, input int rst_beat);
        logic [2:0] code;
        bit fin, go, aborted, hs;
        int w, beats;
        for (int i = 0; i < 8; i++) wbeat[i] = 16'($urandom);
        fin = 1'b0; go = 1'b0; aborted = 1'b0; code = 3'd0;
        // Command accepted in an idle cycle.
        noise();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        cycle();
        cmd_valid = $urandom_range(1); cmd_write = $urandom_range(1);
        cmd_addr = 16'($urandom); cmd_len = 3'($urandom);
        e_cmd_ready = 1'b0; e_barq = 1'b1; e_wr = wr;
        // Waiting for the grant.
        w = 0;
        while (!fin && !go) begin
            noise();
            BAGD = rnd(p_gnt); Error = rnd(p_err);
            cycle();
            if (Error) begin fin = 1'b1; code = 3'd4; end
            else if (w == TO - 1) begin fin = 1'b1; code = 3'd1; end
            else if (BAGD) go = 1'b1;
            else w++;
        end
        // Address phase.
        if (!fin) begin
            e_av = 1'b1; e_addr = addr; e_we = wr; w = 0; go = 1'b0;
            while (!fin && !go) begin
                noise();
                BAGD = !rnd(p_drop); Error = rnd(p_err); TargetReady = rnd(p_tr);
                cycle();
                if (Error) begin fin = 1'b1; code = 3'd4; end
                else if (!BAGD) begin fin = 1'b1; code = 3'd3; end
                else if (w == TO - 1) begin fin = 1'b1; code = 3'd2; end
                else if (TargetReady) go = 1'b1;
                else w++;
            end
        end
        // Data phase.
        if (!fin) begin
            e_av = 1'b0; e_addr = 16'h0000; e_dphase = 1'b1; w = 0; beats = 0;
            while (!fin) begin
                noise();
                BAGD = !rnd(p_drop); Error = rnd(p_err); TargetReady = rnd(p_tr);
                wdata_valid = rnd(p_wv);
                wdata = wr ? wbeat[beats] : 16'($urandom);
                if (beats == rst_beat) begin
                    Reset = 1'b1; TargetReady = 1'b0; Error = 1'b0;
                end
                hs = TargetReady && (!wr || wdata_valid);
                e_wready = wr && hs && !Error && BAGD && (w != TO - 1);
                e_bdo = wbeat[beats];
                cycle();
                if (Reset) begin
                    fin = 1'b1; aborted = 1'b1;
                end else if (Error) begin fin = 1'b1; code = 3'd4; end
                else if (!BAGD) begin fin = 1'b1; code = 3'd3; end
                else if (w == TO - 1) begin fin = 1'b1; code = 3'd2; end
                else if (hs) begin
                    if (!wr) begin e_rvalid = 1'b1; e_rdata = BusDataIn; end
                    if (beats == int'(len)) begin fin = 1'b1; code = 3'd0; end
                    else begin beats++; w = 0; end
                end else w++;
            end
        end
        e_barq = 1'b0; e_av = 1'b0; e_addr = 16'h0000; e_we = 1'b0; e_dphase = 1'b0;
        if (aborted) begin
            // Everything cleared by reset; no done pulse, ready one cycle after release.
            e_rvalid = 1'b0;
            Reset = 1'b0; cmd_valid = 1'b0;
            noise();
            cycle();
            e_cmd_ready = 1'b1;
        end else begin
            e_done = 1'b1; e_status = code;
            noise();
            cycle();
            e_done = 1'b0; e_status = 3'd0; e_cmd_ready = 1'b1;
        end
    endtask

    initial begin
        Reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0000; cmd_len = 3'd0;
        wdata = 16'h0000; wdata_valid = 1'b0; BAGD = 1'b0; TargetReady = 1'b0;
        BusDataIn = 16'h0000; Error = 1'b0;
        e_cmd_ready = 1'b0; e_barq = 1'b0; e_av = 1'b0; e_we = 1'b0; e_dphase = 1'b0;
        e_done = 1'b0; e_rvalid = 1'b0; e_wready = 1'b0; e_wr = 1'b0;
        e_addr = 16'h0000; e_rdata = 16'h0000; e_bdo = 16'h0000; e_status = 3'd0;
        @(posedge clk);
        #1;
        cycle();
        Reset = 1'b0;
        cycle();
        e_cmd_ready = 1'b1;
        idle_cycle();

        run_txn(1'b0, 16'h0040, 3'd0, 300, 700, 0, 0, 1000, -1);  // single read
        run_txn(1'b1, 16'h1234, 3'd3, 500, 700, 0, 0, 600, -1);   // gapped write burst
        run_txn(1'b0, 16'h2000, 3'd1, 0, 500, 0, 0, 1000, -1);    // grant timeout
        run_txn(1'b0, 16'h3000, 3'd3, 1000, 0, 0, 0, 1000, -1);   // target timeout in address
        run_txn(1'b0, 16'h4000, 3'd3, 1000, 800, 0, 150, 1000, -1); // preemption likely
        run_txn(1'b1, 16'h5000, 3'd2, 1000, 500, 300, 0, 800, -1);  // bus error likely
        run_txn(1'b1, 16'h6000, 3'd3, 1000, 900, 0, 0, 1000, 1);    // reset mid-data
        run_txn(1'b0, 16'h7000, 3'd7, 1000, 1000, 0, 0, 1000, -1);  // back-to-back full bursts
        run_txn(1'b1, 16'h7100, 3'd7, 1000, 1000, 0, 0, 1000, -1);

        for (int t = 0; t < 80; t++) begin
            automatic int len_r = $urandom_range(7);
            automatic int p_gnt = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(800, 100));
            automatic int rb = ($urandom_range(11) == 0) ? int'($urandom_range(len_r)) : -1;
            run_txn(1'($urandom), 16'($urandom), 3'(len_r), p_gnt,
                    int'($urandom_range(950, 200)), int'($urandom_range(20)),
                    int'($urandom_range(20)), int'($urandom_range(1000, 300)), rb);
            repeat ($urandom_range(2)) idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
